// File: rtl/clk_freq_monitor_pkg.sv
// Clock-rate constants shared by the clock generator top level and the frequency monitor,
// plus the monitor's state encoding and a small width helper.
package clk_pkg;

  localparam int unsigned F_REF_HZ = 12_000_000;
  localparam int unsigned F_SYS_HZ = 36_000_000;
  localparam int unsigned MEAS_HZ  = 1_000;

  // 1 ms window; the reference is observed through a divide-by-2 toggle.
  localparam int unsigned DEF_WINDOW_CYCLES = F_SYS_HZ / MEAS_HZ;
  localparam int unsigned DEF_EXPECTED      = (F_REF_HZ / 2) / MEAS_HZ;

  typedef enum logic {
    ST_SETTLE  = 1'b0,
    ST_MEASURE = 1'b1
  } mon_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_freq_monitor_if.sv
// Status bundle between the clock monitor (master) and its consumers (LED, game-start gate).
interface clk_freq_monitor_if
  import clk_pkg::*;
#(
  parameter int CW = $clog2(DEF_WINDOW_CYCLES + 1)
);
  logic          ref_toggle;
  logic [CW-1:0] last_count;
  logic          count_valid;
  logic          freq_ok;
  logic          fail_sticky;
  logic          stalled;

  modport master (
    input  ref_toggle,
    output last_count, count_valid, freq_ok, fail_sticky, stalled
  );

  modport slave (
    output ref_toggle,
    input  last_count, count_valid, freq_ok, fail_sticky, stalled
  );
endinterface

// File: rtl/clk_freq_monitor_sync_edge_detect.sv
// Three-flop synchronizer with a rising-edge pulse taken from the two settled stages.
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  assign sync_d = {sync_q[1:0], async_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/clk_freq_monitor.sv
// Counts reference edges per fixed window of the system clock and flags
// out-of-tolerance frequency or a stalled reference.
module clk_freq_monitor
  import clk_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES  = DEF_WINDOW_CYCLES,
  parameter int unsigned EXPECTED       = DEF_EXPECTED,
  parameter int unsigned TOLERANCE      = 8,
  parameter int unsigned SETTLE_WINDOWS = 4,
  parameter int unsigned STALL_CYCLES   = 64,
  parameter int unsigned CW             = $clog2(WINDOW_CYCLES + 1)
) (
  input logic                clk_36MHz,
  input logic                rst,
  clk_freq_monitor_if.master mon
);
  localparam int unsigned WW = max_u($clog2(WINDOW_CYCLES), 1);
  localparam int unsigned SW = max_u($clog2(SETTLE_WINDOWS + 1), 1);
  localparam int unsigned KW = max_u($clog2(STALL_CYCLES + 1), 1);
  // Wide enough that EXPECTED and TOLERANCE always fit, even with a narrow CW.
  localparam int unsigned DW = max_u(CW, $clog2(EXPECTED + TOLERANCE + 1)) + 1;

  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW_CYCLES - 1);
  localparam logic [KW-1:0] STALL_MAX = KW'(STALL_CYCLES);

  logic                 ref_rise;
  logic                 win_last;
  logic                 in_tol;
  logic                 stall_rise;
  logic [CW-1:0]        total;
  logic signed [DW-1:0] dev;
  logic signed [DW-1:0] dev_abs;

  mon_state_e    state_q,       state_d;
  logic [WW-1:0] win_cnt_q,     win_cnt_d;
  logic [CW-1:0] edge_cnt_q,    edge_cnt_d;
  logic [KW-1:0] stall_cnt_q,   stall_cnt_d;
  logic [SW-1:0] settle_cnt_q,  settle_cnt_d;
  logic [CW-1:0] last_count_q,  last_count_d;
  logic          count_valid_q, count_valid_d;
  logic          freq_ok_q,     freq_ok_d;
  logic          fail_sticky_q, fail_sticky_d;
  logic          stalled_q,     stalled_d;

  sync_edge_detect u_sync (
    .clk_i   (clk_36MHz),
    .rst_i   (rst),
    .async_i (mon.ref_toggle),
    .rise_o  (ref_rise)
  );

  // An edge in the closing cycle still belongs to the closing window.
  assign win_last = (win_cnt_q == WIN_LAST);
  assign total    = (edge_cnt_q != CNT_MAX) ? edge_cnt_q + CW'(ref_rise) : edge_cnt_q;
  assign dev      = $signed(DW'(total)) - $signed(DW'(EXPECTED));
  assign dev_abs  = dev[DW-1] ? -dev : dev;
  assign in_tol   = (dev_abs <= $signed(DW'(TOLERANCE)));

  always_comb begin
    win_cnt_d     = win_last ? '0 : win_cnt_q + WW'(1);
    edge_cnt_d    = win_last ? '0 : total;
    stall_cnt_d   = ref_rise ? '0 :
                    (stall_cnt_q == STALL_MAX) ? stall_cnt_q : stall_cnt_q + KW'(1);
    stalled_d     = (stall_cnt_d == STALL_MAX);
    stall_rise    = stalled_d & ~stalled_q;
    state_d       = state_q;
    settle_cnt_d  = settle_cnt_q;
    last_count_d  = last_count_q;
    count_valid_d = 1'b0;
    freq_ok_d     = stalled_d ? 1'b0 : freq_ok_q;
    fail_sticky_d = fail_sticky_q;

    case (state_q)
      ST_SETTLE: begin
        if (SETTLE_WINDOWS == 0) begin
          state_d = ST_MEASURE;
        end else if (win_last) begin
          if (settle_cnt_q == SW'(SETTLE_WINDOWS - 1)) begin
            state_d = ST_MEASURE;
          end else begin
            settle_cnt_d = settle_cnt_q + SW'(1);
          end
        end
      end
      ST_MEASURE: begin
        if (stall_rise) begin
          fail_sticky_d = 1'b1;
        end
        if (win_last) begin
          last_count_d  = total;
          count_valid_d = 1'b1;
          freq_ok_d     = in_tol & ~stalled_d;
          if (!in_tol) begin
            fail_sticky_d = 1'b1;
          end
        end
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk_36MHz) begin
    if (rst) begin
      state_q       <= ST_SETTLE;
      win_cnt_q     <= '0;
      edge_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      settle_cnt_q  <= '0;
      last_count_q  <= '0;
      count_valid_q <= 1'b0;
      freq_ok_q     <= 1'b0;
      fail_sticky_q <= 1'b0;
      stalled_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_cnt_q     <= win_cnt_d;
      edge_cnt_q    <= edge_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      last_count_q  <= last_count_d;
      count_valid_q <= count_valid_d;
      freq_ok_q     <= freq_ok_d;
      fail_sticky_q <= fail_sticky_d;
      stalled_q     <= stalled_d;
    end
  end

  assign mon.last_count  = last_count_q;
  assign mon.count_valid = count_valid_q;
  assign mon.freq_ok     = freq_ok_q;
  assign mon.fail_sticky = fail_sticky_q;
  assign mon.stalled     = stalled_q;
endmodule

// File: tb/tb_clk_freq_monitor.sv
// Bench for clk_freq_monitor: two instances (natural and 3-bit count width) share one
// reference stream; a cycle-history model feeds per-instance report queues.
module tb_clk_freq_monitor;
  import clk_pkg::*;

  localparam int W      = 60;
  localparam int EXP    = 10;
  localparam int TOL    = 1;
  localparam int SETTLE = 1;
  localparam int STALL  = 20;
  localparam int CW_A   = $clog2(W + 1);
  localparam int CW_B   = 3;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic ref_t = 1'b0;

  always #5 clk = ~clk;

  clk_freq_monitor_if #(.CW(CW_A)) if_a ();
  clk_freq_monitor_if #(.CW(CW_B)) if_b ();

  assign if_a.ref_toggle = ref_t;
  assign if_b.ref_toggle = ref_t;

  clk_freq_monitor #(
    .WINDOW_CYCLES(W), .EXPECTED(EXP), .TOLERANCE(TOL),
    .SETTLE_WINDOWS(SETTLE), .STALL_CYCLES(STALL), .CW(CW_A)
  ) dut_a (
    .clk_36MHz (clk),
    .rst       (rst),
    .mon       (if_a.master)
  );

  clk_freq_monitor #(
    .WINDOW_CYCLES(W), .EXPECTED(EXP), .TOLERANCE(TOL),
    .SETTLE_WINDOWS(SETTLE), .STALL_CYCLES(STALL), .CW(CW_B)
  ) dut_b (
    .clk_36MHz (clk),
    .rst       (rst),
    .mon       (if_b.master)
  );

  typedef struct {
    int due;
    int count;
    bit ok;
  } rep_t;

  rep_t sb0[$];
  rep_t sb1[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: cycle index of the cycle now running, counted from reset release.
  int cyc       = 0;
  bit hist[$];
  int last_edge = -1;
  int acc       = 0;
  bit m_stalled = 1'b0;
  bit m_ok[2];
  bit m_sticky[2];
  int m_last[2];

  function automatic int sb_size(int d);
    return (d == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic int sb_head_due(int d);
    return (d == 0) ? sb0[0].due : sb1[0].due;
  endfunction

  function automatic rep_t sb_pop(int d);
    if (d == 0) return sb0.pop_front();
    return sb1.pop_front();
  endfunction

  function automatic void sb_push(int d, rep_t r);
    if (d == 0) sb0.push_back(r);
    else        sb1.push_back(r);
  endfunction

  task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d", name, d, cyc, act, exp);
    end
  endtask

  // Expected behaviour from window arithmetic over the sampled reference history.
  task automatic model_step();
    int  c;
    int  tot;
    int  dev;
    int  sat;
    bit  e;
    bit  st_next;
    bit  tol;
    bit  meas;
    rep_t r;
    if (rst) begin
      cyc       = 0;
      hist.delete();
      last_edge = -1;
      acc       = 0;
      m_stalled = 1'b0;
      for (int d = 0; d < 2; d++) begin
        m_ok[d]     = 1'b0;
        m_sticky[d] = 1'b0;
        m_last[d]   = 0;
      end
      sb0.delete();
      sb1.delete();
    end else begin
      c = cyc;
      hist.push_back(ref_t);
      e = (c >= 2) && hist[c-2] && !((c >= 3) && hist[c-3]);
      if (e) begin
        acc++;
        last_edge = c;
      end
      st_next = (c - last_edge) >= STALL;
      meas    = (c >= W * SETTLE);
      for (int d = 0; d < 2; d++) begin
        if (st_next) m_ok[d] = 1'b0;
        if (meas && st_next && !m_stalled) m_sticky[d] = 1'b1;
        if (meas && (c % W == W - 1)) begin
          sat = (1 << ((d == 0) ? CW_A : CW_B)) - 1;
          tot = (acc > sat) ? sat : acc;
          dev = (tot > EXP) ? tot - EXP : EXP - tot;
          tol = (dev <= TOL);
          m_ok[d]   = tol && !st_next;
          m_last[d] = tot;
          if (!tol) m_sticky[d] = 1'b1;
          r.due   = c + 1;
          r.count = tot;
          r.ok    = m_ok[d];
          sb_push(d, r);
        end
      end
      if (c % W == W - 1) acc = 0;
      m_stalled = st_next;
      cyc       = c + 1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic mon_dut(int d, logic valid, logic [31:0] cnt, logic ok, logic sticky, logic stl);
    rep_t r;
    chk("stalled", d, 32'(stl), 32'(m_stalled));
    chk("freq_ok", d, 32'(ok), 32'(m_ok[d]));
    chk("fail_sticky", d, 32'(sticky), 32'(m_sticky[d]));
    chk("last_count", d, cnt, 32'(m_last[d]));
    if (valid !== 1'b0) begin
      if (sb_size(d) == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_count_valid dut%0d cyc %0d: got count_valid %0b expected 0",
                 d, cyc, valid);
      end else begin
        r = sb_pop(d);
        chk("report_cycle", d, 32'(cyc), 32'(r.due));
        chk("report_count", d, cnt, 32'(r.count));
        chk("report_freq_ok", d, 32'(ok), 32'(r.ok));
        $display("report dut%0d cyc %0d count %0d freq_ok %0b fail_sticky %0b",
                 d, cyc, cnt, ok, sticky);
      end
    end else if (sb_size(d) > 0 && sb_head_due(d) <= cyc) begin
      r = sb_pop(d);
      checks++;
      errors++;
      $display("FAIL missing_count_valid dut%0d cyc %0d: got count_valid 0 expected 1 (count %0d)",
               d, cyc, r.count);
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      mon_dut(0, if_a.count_valid, 32'(if_a.last_count), if_a.freq_ok, if_a.fail_sticky, if_a.stalled);
      mon_dut(1, if_b.count_valid, 32'(if_b.last_count), if_b.freq_ok, if_b.fail_sticky, if_b.stalled);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic square(int period, int n);
    for (int i = 0; i < n; i++) begin
      ref_t = ((i % period) < (period / 2));
      tick();
    end
  endtask

  // One window of n single-cycle pulses starting at offset 'first'.
  task automatic pulses(int n, int first, int step);
    for (int w = 0; w < W; w++) begin
      ref_t = (w >= first) && (((w - first) % step) == 0) && (((w - first) / step) < n);
      tick();
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int first;
    int step;
    ref_t = 1'b0;
    rst   = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Nominal 6-cycle reference from reset, then an edge on a window's last cycle.
    square(6, 4 * W);
    pulses(10, 3, 6);
    pulses(10, 0, 6);
    repeat (4) begin
      n     = int'($urandom_range(9, 11));
      first = int'($urandom_range(0, 4));
      pulses(n, first, 5);
    end

    // Tolerance boundary: 9 and 11 pass, 12 trips the sticky flag which then persists.
    pulses(9, 0, 6);
    pulses(11, 0, 5);
    pulses(12, 0, 5);
    pulses(10, 0, 6);
    pulses(10, 0, 6);

    // Stall inside MEASURE, then recovery.
    reset_pulse();
    square(6, 2 * W);
    ref_t = 1'b0;
    repeat (40) tick();
    square(6, 200);

    // Reset at window cycle 30 of a MEASURE window.
    square(6, 30);
    reset_pulse();
    square(6, 3 * W);

    // Edge every 2 cycles: saturates the narrow instance.
    square(2, 2 * W);

    repeat (6) begin
      n     = int'($urandom_range(0, 20));
      step  = (n == 0) ? 2 : 55 / n;
      first = int'($urandom_range(0, 3));
      pulses(n, first, step);
    end
    ref_t = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_freq_monitor.md
# clk_freq_monitor

Runtime check of the 36 MHz PLL clock against the 12 MHz board oscillator. Runs entirely in the `clk_36MHz` domain and counts rising edges of `ref_toggle`, a divide-by-2 toggle of `clk_12MHz` (6 MHz square wave), over a fixed window. It flags out-of-tolerance frequency and a stalled reference. Sits beside the clock generator at top level; outputs drive a status LED and gate game-logic start.

## Interface
Parameters:
- `WINDOW_CYCLES`, 36000: measurement window length in `clk_36MHz` cycles (1 ms).
- `EXPECTED`, 6000: expected `ref_toggle` rising edges per window.
- `TOLERANCE`, 8: allowed absolute deviation from `EXPECTED`, inclusive.
- `SETTLE_WINDOWS`, 4: windows discarded after reset (PLL lock time).
- `STALL_CYCLES`, 64: cycles without a reference edge before `stalled` asserts.
- `CW`, `$clog2(WINDOW_CYCLES+1)`: count width (derived).

Ports:
- `clk_36MHz` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `ref_toggle` in 1: asynchronous reference square wave.
- `last_count` out CW: edge count of the most recent reported window.
- `count_valid` out 1: one-cycle pulse when `last_count` updates.
- `freq_ok` out 1: last reported window within tolerance and not stalled.
- `fail_sticky` out 1: any post-settle failure since reset.
- `stalled` out 1: no reference edge for `STALL_CYCLES`.

## Operation
- **Sync and edge detect:** `s1<=ref_toggle; s2<=s1; s3<=s2; edge = s2 & ~s3`.
- **Window counter:** runs 0..WINDOW_CYCLES-1, then wraps. The cycle with value WINDOW_CYCLES-1 is the window's last cycle.
- **Edge counter:** increments on `edge` and saturates at 2^CW-1. On the last cycle of a window it clears to 0, and an edge in that cycle is included in the closing window's total.
- **FSM, SETTLE:** closes windows without reporting. After SETTLE_WINDOWS completed windows it moves to MEASURE. With SETTLE_WINDOWS=0 it enters MEASURE immediately after reset.
- **FSM, MEASURE:** at each window close:
  - `last_count` <= total; `count_valid` pulses for one cycle.
  - `freq_ok` <= (|total-EXPECTED| <= TOLERANCE) & ~stalled.
  - An out-of-tolerance result sets `fail_sticky`.
- **Arithmetic:** deviation is computed in CW+1 bits signed; no wrap.
- **Stall counter:** clears on `edge`, otherwise increments and saturates at STALL_CYCLES. `stalled` = (counter == STALL_CYCLES), registered.
- **When `stalled` rises:** `freq_ok` clears in the same cycle. In MEASURE it also sets `fail_sticky`. `stalled` clears the cycle after the next edge.
- **`freq_ok` after a stall:** stays 0 until the next in-tolerance window close.
- **`fail_sticky`:** cleared only by `rst`.

## Timing
- **Reset values:** all outputs 0. FSM resets to SETTLE; all counters reset to 0.
- **Reset priority:** reset mid-window or mid-MEASURE aborts the window and restarts settling. Reset wins over any simultaneous event.
- **Edge latency:** a `ref_toggle` rise at input cycle n produces `edge` at n+2.
- **Report latency:**
  - `last_count`, `count_valid` and `freq_ok` change on the clock edge ending the window's last cycle (visible in cycle 0 of the next window).
  - `count_valid` is high for exactly 1 cycle per MEASURE window.
- **Simultaneous window close and stall rise:** `freq_ok` = 0.

## Structure
- Shared package/header `clk_pkg`: clock-rate constants (`F_REF_HZ`=12_000_000, `F_SYS_HZ`=36_000_000) and the derived defaults for `WINDOW_CYCLES`/`EXPECTED`. Both the generator top level and this block use them.
- One sub-module, `sync_edge_detect`: 3-flop synchronizer plus rising-edge output, reusable for button inputs.

## Test plan
All scenarios use WINDOW_CYCLES=60, EXPECTED=10, TOLERANCE=1, SETTLE_WINDOWS=1, STALL_CYCLES=20.
- **Nominal:** `ref_toggle` period 6 cycles from reset.
  - No `count_valid` during the first window.
  - Thereafter a pulse every 60 cycles with `last_count`=10, `freq_ok`=1, `fail_sticky`=0.
- **Tolerance boundary:** force window totals of 9, 11, 12.
  - 9 and 11 give `freq_ok`=1.
  - 12 gives `freq_ok`=0 and `fail_sticky`=1; the sticky flag persists through later windows of 10.
- **Stall:** hold `ref_toggle` low in MEASURE.
  - `stalled`=1 and `freq_ok`=0 exactly 20 cycles after the last edge; `fail_sticky`=1.
  - On resume, `stalled`=0 one cycle after the first edge; `freq_ok` returns at the next window of 10.
- **Edge on the last window cycle:** edge arrives on the last cycle of a window.
  - Counted in the closing window (total 10, not 9).
  - The next window starts at 0.
- **Reset mid-MEASURE:** assert `rst` at window cycle 30.
  - All outputs 0 the next cycle.
  - One full settle window elapses before the next `count_valid`.
- **Saturation:** WINDOW_CYCLES=60, CW forced to 3, edge every 2 cycles → `last_count`=7 (saturated), `freq_ok`=0.
